timer_rr_scheduler: RTL and testbench

Round-robin scheduler that shares a single up-counter interval timer among four requesters. Each requester asks for a delay of N clock cycles. The block grants the timer to one requester at a time, latches that requester's duration into an internal enabled register, runs the counter from zero, and returns a one-cycle done pulse to the granted requester. It sits between the requesting control FSMs and the shared counter/register datapath, and owns both the sequencing and the arbitration.

---
 rtl/timer_rr_scheduler.sv | 100 ++++++++++
 tb/tb_timer_rr_scheduler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/timer_rr_scheduler.sv
// Round-robin scheduler sharing one up-counter interval timer among four requesters.
// Grants one requester, runs the counter to its latched duration, then pulses oDone to it.
module timer_rr_scheduler #(
  parameter int unsigned SIZE = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [3:0]          iReq,
  input  logic [4*SIZE-1:0]   iDuration,
  output logic [3:0]          oGrant,
  output logic [3:0]          oDone,
  output logic                oBusy,
  output logic [SIZE-1:0]     oCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_grant;
  logic [1:0]        r_last;
  logic [SIZE-1:0]   r_dur;
  logic [SIZE-1:0]   r_count;

  logic              w_found;
  logic [1:0]        w_sel;
  logic [SIZE-1:0]   w_sel_dur;
  logic [SIZE-1:0]   w_last_cnt;
  logic              w_cnt_end;

  // First set request scanning upward from the one after the previous grant.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && iReq[r_last + 2'(k)]) begin
        w_found = 1'b1;
        w_sel   = r_last + 2'(k);
      end
    end
  end

  assign w_sel_dur  = iDuration[32'(w_sel) * SIZE +: SIZE];
  // Zero duration behaves as one; terminal count never exceeds dur-1, so no wrap.
  assign w_last_cnt = (r_dur == '0) ? '0 : r_dur - SIZE'(1);
  assign w_cnt_end  = (r_count == w_last_cnt);

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_LOAD;
      S_LOAD:  w_next = S_COUNT;
      S_COUNT: if (w_cnt_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant, rotation pointer, latched duration and timer counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_grant <= 4'd0;
      r_last  <= 2'd3;
      r_dur   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= 4'b0001 << w_sel;
            r_last  <= w_sel;
            r_dur   <= w_sel_dur;
          end
        end
        S_LOAD:  r_count <= '0;
        S_COUNT: if (!w_cnt_end) r_count <= r_count + SIZE'(1);
        S_DONE:  r_grant <= 4'd0;
        default: r_grant <= 4'd0;
      endcase
    end
  end

  always_comb begin
    oGrant = r_grant;
    oCount = r_count;
    oBusy  = (r_state != S_IDLE);
    oDone  = (r_state == S_DONE) ? r_grant : 4'd0;
  end

endmodule

// File: tb/tb_timer_rr_scheduler.sv
// Directed bench for timer_rr_scheduler: table of single services plus
// hand-written withdrawal, mid-count reset and maximum-duration sequences.
module tb_timer_rr_scheduler;

  localparam int unsigned SIZE = 16;

  logic                Clock;
  logic                Reset;
  logic [3:0]          iReq;
  logic [4*SIZE-1:0]   iDuration;
  logic [3:0]          oGrant;
  logic [3:0]          oDone;
  logic                oBusy;
  logic [SIZE-1:0]     oCount;

  int checks = 0;
  int errors = 0;

  timer_rr_scheduler #(.SIZE(SIZE)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iReq      (iReq),
    .iDuration (iDuration),
    .oGrant    (oGrant),
    .oDone     (oDone),
    .oBusy     (oBusy),
    .oCount    (oCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] dur;
    int          idx;
    int          eff;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits for a grant to idx, then follows it cycle by cycle until it drops.
  // At cycle mod_at of the grant, the request is withdrawn and its duration changed.
  task automatic run_service(input int idx, input int eff, input int mod_at);
    int         lat;
    logic [3:0] oh;
    oh  = 4'b0001 << idx;
    lat = 0;
    do begin
      @(negedge Clock);
      lat++;
    end while (oGrant == 4'd0 && lat < 20);
    check("grant_latency", 64'(lat), 64'd1);
    check("grant", 64'(oGrant), 64'(oh));
    check("busy_load", 64'(oBusy), 64'd1);
    check("done_load", 64'(oDone), 64'd0);
    for (int c = 1; c <= eff + 1; c++) begin
      @(negedge Clock);
      check("grant_hold", 64'(oGrant), 64'(oh));
      check("busy_hold", 64'(oBusy), 64'd1);
      if (c <= eff) begin
        check("count", 64'(oCount), 64'(c - 1));
        check("done_early", 64'(oDone), 64'd0);
      end else begin
        check("done_pulse", 64'(oDone), 64'(oh));
        check("count_hold", 64'(oCount), 64'(eff - 1));
      end
      if (c == mod_at) begin
        iReq = 4'd0;
        iDuration[idx*SIZE +: SIZE] = 16'd100;
      end
    end
    @(negedge Clock);
    check("grant_release", 64'(oGrant), 64'd0);
    check("busy_idle", 64'(oBusy), 64'd0);
    check("done_idle", 64'(oDone), 64'd0);
  endtask

  initial begin
    int lat;

    vecs[0] = '{req: 4'b0001, dur: {16'd0, 16'd0, 16'd0, 16'd5}, idx: 0, eff: 5};
    vecs[1] = '{req: 4'b1111, dur: {4{16'd3}},                  idx: 1, eff: 3};
    vecs[2] = '{req: 4'b1111, dur: {4{16'd3}},                  idx: 2, eff: 3};
    vecs[3] = '{req: 4'b1111, dur: {4{16'd3}},                  idx: 3, eff: 3};
    vecs[4] = '{req: 4'b1111, dur: {4{16'd3}},                  idx: 0, eff: 3};
    vecs[5] = '{req: 4'b0100, dur: {4{16'd0}},                  idx: 2, eff: 1};
    vecs[6] = '{req: 4'b1001, dur: {16'd4, 16'd0, 16'd0, 16'd2}, idx: 3, eff: 4};
    vecs[7] = '{req: 4'b1001, dur: {16'd4, 16'd0, 16'd0, 16'd2}, idx: 0, eff: 2};

    Reset     = 1'b1;
    iReq      = 4'b1111;
    iDuration = {4{16'd3}};
    repeat (3) @(negedge Clock);
    check("rst_grant", 64'(oGrant), 64'd0);
    check("rst_done", 64'(oDone), 64'd0);
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_count", 64'(oCount), 64'd0);
    Reset = 1'b0;
    iReq  = 4'd0;

    for (int v = 0; v < 8; v++) begin
      iReq      = vecs[v].req;
      iDuration = vecs[v].dur;
      run_service(vecs[v].idx, vecs[v].eff, -1);
    end

    // Withdrawal and late duration change during an 8-cycle interval.
    iReq      = 4'b0010;
    iDuration = {16'd0, 16'd0, 16'd8, 16'd0};
    run_service(1, 8, 3);

    // Reset during COUNT of requester 2 with every request active.
    iReq      = 4'b1111;
    iDuration = {4{16'd10}};
    lat = 0;
    do begin
      @(negedge Clock);
      lat++;
    end while (oGrant == 4'd0 && lat < 20);
    check("abort_grant", 64'(oGrant), 64'b0100);
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clock);
      check("abort_no_done", 64'(oDone), 64'd0);
    end
    Reset = 1'b1;
    @(negedge Clock);
    check("abort_grant_clr", 64'(oGrant), 64'd0);
    check("abort_done_clr", 64'(oDone), 64'd0);
    check("abort_busy_clr", 64'(oBusy), 64'd0);
    check("abort_count_clr", 64'(oCount), 64'd0);
    Reset = 1'b0;
    run_service(0, 10, -1);

    // Maximum duration: counter must stop at FFFE.
    iReq      = 4'b0001;
    iDuration = {16'd0, 16'd0, 16'd0, 16'hFFFF};
    run_service(0, 65535, -1);
    iReq = 4'd0;
    repeat (2) @(negedge Clock);
    check("final_idle", 64'(oBusy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
